// File: rtl/secure_link_pkg.sv
// Shared constants for the secure link: Hamming(7,4) codeword layout,
// syndrome-to-bit mapping and the receiver output-register states.
package secure_link_pkg;

    localparam int CW_W   = 7;
    localparam int DATA_W = 4;
    localparam int PORT_W = 2;
    localparam int NPORTS = 4;

    localparam int P1_IDX = 6;
    localparam int P2_IDX = 5;
    localparam int D3_IDX = 4;
    localparam int P3_IDX = 3;
    localparam int D2_IDX = 2;
    localparam int D1_IDX = 1;
    localparam int D0_IDX = 0;

    // Syndrome {s1,s2,s3} value that points at each codeword bit.
    localparam logic [2:0] SYN_NONE = 3'b000;
    localparam logic [2:0] SYN_C0   = 3'b111;
    localparam logic [2:0] SYN_C1   = 3'b011;
    localparam logic [2:0] SYN_C2   = 3'b101;
    localparam logic [2:0] SYN_C3   = 3'b001;
    localparam logic [2:0] SYN_C4   = 3'b110;
    localparam logic [2:0] SYN_C5   = 3'b010;
    localparam logic [2:0] SYN_C6   = 3'b100;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/hamming74_dec.sv
// Combinational Hamming(7,4) decoder: corrects any single-bit error and
// flags that a correction took place.
module hamming74_dec
    import secure_link_pkg::*;
(
    input  logic [CW_W-1:0]   cw_i,
    output logic [DATA_W-1:0] data_o,
    output logic              err_fix_o
);

    logic [2:0] syn;

    always_comb begin
        syn[2] = cw_i[P1_IDX] ^ cw_i[D3_IDX] ^ cw_i[D2_IDX] ^ cw_i[D0_IDX];
        syn[1] = cw_i[P2_IDX] ^ cw_i[D3_IDX] ^ cw_i[D1_IDX] ^ cw_i[D0_IDX];
        syn[0] = cw_i[P3_IDX] ^ cw_i[D2_IDX] ^ cw_i[D1_IDX] ^ cw_i[D0_IDX];

        // Only data bits are ever flipped; a parity-bit error leaves data intact.
        data_o = {cw_i[D3_IDX] ^ (syn == SYN_C4),
                  cw_i[D2_IDX] ^ (syn == SYN_C2),
                  cw_i[D1_IDX] ^ (syn == SYN_C1),
                  cw_i[D0_IDX] ^ (syn == SYN_C0)};
        err_fix_o = (syn != SYN_NONE);
    end

endmodule

// File: rtl/secure_receiver.sv
// Four-port Hamming(7,4) receiver with round-robin arbitration and a one-entry
// output register. Optional corrected-error counter under SECURE_RX_ERR_CNT_EN.
module secure_receiver
    import secure_link_pkg::*;
#(
`ifdef SECURE_RX_ERR_CNT_EN
    parameter int CNT_W   = 8,
`endif
    parameter int RR_INIT = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CW_W-1:0]          d_in0,
    input  logic [CW_W-1:0]          d_in1,
    input  logic [CW_W-1:0]          d_in2,
    input  logic [CW_W-1:0]          d_in3,
    input  logic [NPORTS-1:0]        in_valid,
    output logic [NPORTS-1:0]        in_ready,
    output logic [PORT_W+DATA_W-1:0] d_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     err_fix
`ifdef SECURE_RX_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0]         err_cnt
`endif
);

    // Handshake: a codeword on port i transfers in a cycle where in_valid[i]
    // and in_ready[i] are both high; d_out transfers when out_valid and out_ready.
    out_state_e                 state_q, state_d;
    logic [PORT_W-1:0]          ptr_q, ptr_d;
    logic [PORT_W+DATA_W-1:0]   dout_q, dout_d;
    logic                       fix_q, fix_d;

    logic [PORT_W-1:0]          gnt_idx;
    logic                       gnt_any;
    logic                       load;
    logic [CW_W-1:0]            cw_sel;
    logic [DATA_W-1:0]          dec_data;
    logic                       dec_fix;

    // Scan ptr, ptr+1, ... with 2-bit wraparound; first valid port wins.
    always_comb begin
        gnt_idx = ptr_q;
        gnt_any = 1'b0;
        for (int k = 0; k < NPORTS; k++) begin
            if (!gnt_any && in_valid[ptr_q + PORT_W'(k)]) begin
                gnt_any = 1'b1;
                gnt_idx = ptr_q + PORT_W'(k);
            end
        end
    end

    always_comb begin
        cw_sel = d_in0;
        case (gnt_idx)
            2'd0: cw_sel = d_in0;
            2'd1: cw_sel = d_in1;
            2'd2: cw_sel = d_in2;
            2'd3: cw_sel = d_in3;
            default: cw_sel = d_in0;
        endcase
    end

    hamming74_dec u_dec (
        .cw_i      (cw_sel),
        .data_o    (dec_data),
        .err_fix_o (dec_fix)
    );

    assign load     = !rst && gnt_any && ((state_q == OUT_EMPTY) || out_ready);
    assign in_ready = load ? (NPORTS'(1) << gnt_idx) : '0;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        dout_d  = dout_q;
        fix_d   = fix_q;
        if (load) begin
            state_d = OUT_FULL;
            ptr_d   = gnt_idx + PORT_W'(1);
            dout_d  = {gnt_idx, dec_data};
            fix_d   = dec_fix;
        end else if ((state_q == OUT_FULL) && out_ready) begin
            state_d = OUT_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OUT_EMPTY;
            ptr_q   <= PORT_W'(RR_INIT);
            dout_q  <= '0;
            fix_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            dout_q  <= dout_d;
            fix_q   <= fix_d;
        end
    end

    assign out_valid = (state_q == OUT_FULL);
    assign d_out     = dout_q;
    assign err_fix   = fix_q;

`ifdef SECURE_RX_ERR_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturating: stops at all-ones until the next reset.
    always_comb begin
        cnt_d = cnt_q;
        if (load && dec_fix && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign err_cnt = cnt_q;
`endif

endmodule
